// File: rtl/memoria_escritura.sv
// Sample recorder: a slow-sampled button writes data_in into an internal RAM at sequential addresses.
// Define MEMORIA_WRAP_EN to overwrite the oldest entries once full instead of blocking writes.
//
// state   | meaning
// IDLE    | waiting for a button request
// CAPTURE | data_in latched, write pending
// WRITE   | RAM written and pointer advanced at end of cycle
// FULL    | log full, requests ignored until clear (unused with MEMORIA_WRAP_EN)
module memoria_escritura #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 8,
    parameter int DIV_COUNT     = 50000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic                     clear,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic [ADDRESS_WIDTH-1:0] rd_address,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic [ADDRESS_WIDTH-1:0] wr_address,
    output logic [ADDRESS_WIDTH:0]   count,
    output logic                     full,
    output logic                     busy,
    output logic                     wr_ack
);
    localparam int DEPTH = 1 << ADDRESS_WIDTH;
    localparam int PW    = (DIV_COUNT > 2) ? $clog2(DIV_COUNT) : 1;
    localparam logic [PW-1:0]          PRE_LAST  = PW'(DIV_COUNT - 1);
    localparam logic [ADDRESS_WIDTH:0] DEPTH_CNT = (ADDRESS_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, CAPTURE, WRITE, FULL} state_t;

    state_t                   state, state_next;
    logic [PW-1:0]            pre_cnt;
    logic                     tick;
    logic                     we_meta, we_sync, we_prev;
    logic                     req;
    logic                     mem_we;
    logic [DATA_WIDTH-1:0]    data_reg;
    logic [ADDRESS_WIDTH:0]   count_inc;
    logic [DATA_WIDTH-1:0]    mem [DEPTH];

    assign tick      = (pre_cnt == PRE_LAST);
    assign req       = tick & we_sync & ~we_prev;
    assign count_inc = count + 1'b1;
    assign full      = (count == DEPTH_CNT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt <= '0;
            we_meta <= 1'b0;
            we_sync <= 1'b0;
            we_prev <= 1'b0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            we_meta <= we;
            we_sync <= we_meta;
            if (tick)
                we_prev <= we_sync;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (req) state_next = CAPTURE;
                CAPTURE: state_next = WRITE;
`ifdef MEMORIA_WRAP_EN
                WRITE:   state_next = IDLE;
                FULL:    state_next = IDLE;
`else
                WRITE:   state_next = (count_inc == DEPTH_CNT) ? FULL : IDLE;
                FULL:    state_next = FULL;
`endif
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        busy   = 1'b0;
        mem_we = 1'b0;
        case (state)
            CAPTURE: busy = 1'b1;
            WRITE: begin
                busy   = 1'b1;
                mem_we = ~clear;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_reg   <= '0;
            wr_address <= '0;
            count      <= '0;
            wr_ack     <= 1'b0;
        end else begin
            wr_ack <= mem_we;
            if (state == IDLE && req && !clear)
                data_reg <= data_in;
            if (clear) begin
                wr_address <= '0;
                count      <= '0;
            end else if (mem_we) begin
                wr_address <= wr_address + 1'b1;
`ifdef MEMORIA_WRAP_EN
                count      <= full ? count : count_inc;
`else
                count      <= count_inc;
`endif
            end
        end
    end

    // RAM has no reset so it maps onto block memory; read returns pre-write data on collisions.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[wr_address] <= data_reg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rd_data <= '0;
        else
            rd_data <= mem[rd_address];
    end
endmodule

// File: tb/tb_memoria_escritura.sv
// Scoreboard bench for memoria_escritura: a press-level model predicts each write, a monitor checks every wr_ack.
module tb_memoria_escritura;
    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DIV   = 4;
    localparam int DEPTH = 4;
`ifdef MEMORIA_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          we = 1'b0;
    logic          clear = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [AW-1:0] rd_address = '0;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] wr_address;
    logic [AW:0]   count;
    logic          full;
    logic          busy;
    logic          wr_ack;

    memoria_escritura #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DIV_COUNT(DIV)) dut (
        .clk(clk), .rst(rst), .we(we), .clear(clear), .data_in(data_in),
        .rd_address(rd_address), .rd_data(rd_data), .wr_address(wr_address),
        .count(count), .full(full), .busy(busy), .wr_ack(wr_ack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int addr;
        int cnt;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    int m_mem[DEPTH];
    bit m_valid[DEPTH];
    int m_wptr = 0;
    int m_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && wr_ack) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_wr_ack", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("ack_wr_address", 32'(wr_address), 32'(mon_e.addr));
                chk("ack_count", 32'(count), 32'(mon_e.cnt));
                chk("ack_full", 32'(full), 32'(mon_e.cnt == DEPTH));
            end
        end
    end

    task automatic check_state(input string tag);
        chk({tag, "_count"}, 32'(count), 32'(m_cnt));
        chk({tag, "_wr_address"}, 32'(wr_address), 32'(m_wptr));
        chk({tag, "_full"}, 32'(full), 32'(m_cnt == DEPTH));
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic press(input logic [DW-1:0] d, input int hold_ticks);
        data_in = d;
        if (!clear && (m_cnt < DEPTH || WRAP)) begin
            m_mem[m_wptr]   = int'(d);
            m_valid[m_wptr] = 1'b1;
            m_wptr = (m_wptr + 1) % DEPTH;
            if (m_cnt < DEPTH) m_cnt++;
            sb_q.push_back('{addr: m_wptr, cnt: m_cnt});
        end
        we = 1'b1;
        repeat (hold_ticks * DIV) @(negedge clk);
        we = 1'b0;
        repeat (3 * DIV) @(negedge clk);
        chk("pending_writes", 32'(sb_q.size()), 0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        m_wptr = 0;
        m_cnt = 0;
        repeat (2) @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        check_state("clear");
    endtask

    task automatic read_chk(input int a);
        rd_address = AW'(a);
        @(negedge clk);
        if (m_valid[a]) chk("rd_data", 32'(rd_data), 32'(m_mem[a]));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rd_data"}, 32'(rd_data), 0);
        chk({tag, "_wr_address"}, 32'(wr_address), 0);
        chk({tag, "_count"}, 32'(count), 0);
        chk({tag, "_full"}, 32'(full), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_wr_ack"}, 32'(wr_ack), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        int r;
        // Reset with button held, then idle with no press.
        we = 1'b1;
        repeat (5) @(negedge clk);
        check_zero("reset");
        we = 1'b0;
        rst = 1'b1;
        repeat (40) @(negedge clk);
        check_state("idle");

        // Single write and read-back.
        press(8'hA5, 3);
        check_state("single");
        read_chk(0);

        // Held button yields one write; second press lands at address 1.
        do_clear();
        press(8'h5A, 20);
        check_state("held");
        press(8'h3C, 3);
        check_state("second");
        read_chk(1);

        // Fill then overflow.
        do_clear();
        press(8'h11, 3);
        press(8'h22, 3);
        press(8'h33, 3);
        press(8'h44, 3);
        check_state("filled");
        press(8'h55, 3);
        check_state("overflow");
        for (int i = 0; i < DEPTH; i++) read_chk(i);

        // Clear covering a request drops it; RAM retained.
        clear = 1'b1;
        m_wptr = 0;
        m_cnt = 0;
        press(8'h99, 3);
        clear = 1'b0;
        @(negedge clk);
        check_state("clear_req");
        read_chk(1);

        // Randomized phase.
        for (int k = 0; k < 16; k++) begin
            r = int'($urandom_range(0, 9));
            if (r < 2) do_clear();
            else if (r < 4) read_chk(int'($urandom_range(0, DEPTH - 1)));
            else begin
                press(DW'($urandom), int'($urandom_range(2, 4)));
                check_state("rand");
            end
        end

        // Reset during WRITE aborts the write.
        do_clear();
        data_in = 8'hE7;
        we = 1'b1;
        n = 0;
        while (!busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("busy_seen", 32'(busy), 1);
        @(negedge clk);
        chk("busy_in_write", 32'(busy), 1);
        we = 1'b0;
        rst = 1'b0;
        #1;
        check_zero("midwrite_reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        check_state("after_reset");

        chk("scoreboard_empty", 32'(sb_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
